ks_poly_string: RTL and testbench
=================================

Name: ks_poly_string

Overview:
Time-multiplexed polyphonic Karplus-Strong string engine. N_VOICES independent plucked strings share one circular-buffer sample memory and one averaging/decay datapath. A sample-rate tick starts each frame, and each frame updates every voice once. The block emits per-voice samples and a widened mix, and sits between the PRBS noise source and the audio output/DAC stage.

Parameters:
N_VOICES, 4, number of voices (power of two, >=2)
MAX_LENGTH, 256, maximum delay-line length per voice (power of two)
DATA_WIDTH, 8, signed sample width
PRBS_WIDTH, 2, noise input width (>=2)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
sample_tick_i  in  1  one-cycle frame start strobe
freeze_i  in  1  sampled at frame start; hold all string state for that frame
prbs_data_i  in  PRBS_WIDTH  noise source; only bits [1:0] are used
pluck_valid_i  in  1  pluck command valid
pluck_ready_o  out  1  pluck command accepted when valid&&ready
pluck_voice_i  in  $clog2(N_VOICES)  target voice
pluck_period_i  in  $clog2(MAX_LENGTH)+1  delay length in samples
pluck_decay_i  in  DATA_WIDTH  unsigned loop gain, Q0.DATA_WIDTH
voice_sample_o  out  DATA_WIDTH  signed sample of voice voice_idx_o
voice_idx_o  out  $clog2(N_VOICES)  voice index of voice_sample_o
voice_valid_o  out  1  one-cycle pulse per voice per frame
mix_o  out  DATA_WIDTH+$clog2(N_VOICES)  signed sum of all voice samples for the frame
mix_valid_o  out  1  one-cycle pulse per frame
busy_o  out  1  high in any state other than IDLE
overrun_o  out  1  sticky; set if sample_tick_i arrives while not IDLE

Behaviour:
- Memory: one N_VOICES*MAX_LENGTH x DATA_WIDTH array with synchronous read, addressed {voice, ptr}. Per-voice registers: period, decay, ptr, burst_cnt, last_x.
- Reset: all outputs 0. FSM enters CLEAR, which writes 0 to every address, one per cycle, over N_VOICES*MAX_LENGTH cycles. During CLEAR, busy_o=1 and pluck_ready_o=0. Per-voice registers reset to period=2, decay=0, ptr=0, burst_cnt=0, last_x=0.
- Reset asserted mid-frame or mid-CLEAR aborts the operation and restarts CLEAR.
- FSM states: CLEAR -> IDLE. IDLE --sample_tick_i--> RD(v=0). RD -> WR. WR -> RD(v+1), or MIX after v=N_VOICES-1. MIX -> IDLE.
- Frame timing: each voice takes 2 cycles and a frame takes 2*N_VOICES+1 cycles. With the tick at cycle t, the voice v output is registered and visible with voice_valid_o=1 at cycle t+2v+3. mix_valid_o=1 at cycle t+2N_VOICES+2.
- RD: issue read at {v, ptr}.
- WR: x_p = read data; avg = x_p + last_x (DATA_WIDTH+1 bits, signed).
  - If burst_cnt>0: y = noise, where prbs[1]=0 -> 0; prbs[1:0]=11 -> +(2^(DATA_WIDTH-1)-1); prbs[1:0]=10 -> -(2^(DATA_WIDTH-1)-1). burst_cnt decrements.
  - Otherwise: y = (avg * decay) >>> (DATA_WIDTH+1), arithmetic shift, truncating toward -inf. y cannot overflow DATA_WIDTH.
  - Write y to {v, ptr}; last_x <= x_p; ptr <= (ptr==period-1) ? 0 : ptr+1; voice_sample_o <= y.
- freeze_i latched at tick=1: in WR there is no write, no ptr/burst_cnt/last_x update, and voice_sample_o <= x_p. Valid pulses still occur.
- MIX: mix_o <= sign-extended sum of the frame's N_VOICES y values. mix_o holds until the next MIX.
- pluck_ready_o=1 only in IDLE. On acceptance, period is clamped: values <2 become 2, values >MAX_LENGTH become MAX_LENGTH. Then period<=clamped, decay<=pluck_decay_i, ptr<=0, burst_cnt<=clamped, last_x<=0.
- Pluck and tick in the same IDLE cycle: both are accepted, and the pluck takes effect for the frame that starts.
- A re-pluck of an active voice fully restarts it. Memory beyond the new period is ignored.
- Tick outside IDLE (including CLEAR) is dropped and sets overrun_o. Only reset clears overrun_o.

Test Plan:
- Reset, then count cycles -> busy_o high exactly N_VOICES*MAX_LENGTH=1024 cycles, pluck_ready_o=0 throughout, then IDLE with all outputs 0.
- Pluck voice 0 (period=4, decay=255, prbs=2'b11), then tick 6 frames -> voice 0 outputs 127,127,127,127,63,126. Other voices output 0 and mix equals the voice 0 value.
- Pluck voice 1 (period=1, decay=255, prbs=2'b10) -> period clamps to 2. Outputs -127,-127, then -64 = (-127*255)>>>9, then -127.
- Tick at cycle t -> voice_valid_o at t+3, t+5, t+7, t+9 with voice_idx_o 0..3. mix_valid_o at t+10 only. A second tick at t+4 sets overrun_o=1 and leaves the frame unaffected.
- Voices 0 and 2 bursting +127, freeze_i=1 for one frame -> outputs repeat the stored samples and ptr does not advance. The next unfrozen frame continues the sequence unchanged; mix_o=254 during the burst.
- Reset asserted mid-frame (during RD of voice 2) -> next cycle enters CLEAR, outputs 0, and all voices stay silent after CLEAR.

Source files
------------

// File: rtl/ks_poly_string.sv
// Time-multiplexed polyphonic Karplus-Strong string engine: N_VOICES plucked strings
// share one circular-buffer sample memory and one averaging/decay datapath per frame.
module ks_poly_string #(
  parameter int N_VOICES   = 4,
  parameter int MAX_LENGTH = 256,
  parameter int DATA_WIDTH = 8,
  parameter int PRBS_WIDTH = 2
) (
  input  logic                                       clk_i,
  input  logic                                       rst_i,
  input  logic                                       sample_tick_i,
  input  logic                                       freeze_i,
  input  logic [PRBS_WIDTH-1:0]                      prbs_data_i,
  input  logic                                       pluck_valid_i,
  output logic                                       pluck_ready_o,
  input  logic [$clog2(N_VOICES)-1:0]                pluck_voice_i,
  input  logic [$clog2(MAX_LENGTH):0]                pluck_period_i,
  input  logic [DATA_WIDTH-1:0]                      pluck_decay_i,
  output logic [DATA_WIDTH-1:0]                      voice_sample_o,
  output logic [$clog2(N_VOICES)-1:0]                voice_idx_o,
  output logic                                       voice_valid_o,
  output logic [DATA_WIDTH+$clog2(N_VOICES)-1:0]     mix_o,
  output logic                                       mix_valid_o,
  output logic                                       busy_o,
  output logic                                       overrun_o
);
  localparam int VW    = $clog2(N_VOICES);
  localparam int AW    = $clog2(MAX_LENGTH);
  localparam int PW    = AW + 1;
  localparam int MW    = DATA_WIDTH + VW;
  localparam int CW    = VW + AW;
  localparam int DEPTH = N_VOICES * MAX_LENGTH;
  localparam int PRODW = 2 * DATA_WIDTH + 2;
  localparam logic signed [DATA_WIDTH-1:0] NOISE_POS = DATA_WIDTH'((1 << (DATA_WIDTH - 1)) - 1);
  localparam logic signed [DATA_WIDTH-1:0] NOISE_NEG = -NOISE_POS;
  localparam logic [CW-1:0] CLR_LAST = CW'(DEPTH - 1);
  localparam logic [PW-1:0] PER_MIN  = PW'(2);
  localparam logic [PW-1:0] PER_MAX  = PW'(MAX_LENGTH);

  typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_RD, S_WR, S_MIX} state_t;

  state_t                        state_q, state_d;
  logic [VW-1:0]                 voice_q, voice_d;
  logic [CW-1:0]                 clr_q, clr_d;
  logic                          freeze_q, freeze_d;
  logic signed [MW-1:0]          acc_q, acc_d;
  logic                          overrun_q, overrun_d;
  logic signed [DATA_WIDTH-1:0]  sample_q, sample_d;
  logic [VW-1:0]                 idx_q, idx_d;
  logic                          vvalid_q, vvalid_d;
  logic signed [MW-1:0]          mix_q, mix_d;
  logic                          mvalid_q, mvalid_d;

  logic [PW-1:0]                 period_q [N_VOICES];
  logic [PW-1:0]                 period_d [N_VOICES];
  logic [DATA_WIDTH-1:0]         decay_q  [N_VOICES];
  logic [DATA_WIDTH-1:0]         decay_d  [N_VOICES];
  logic [AW-1:0]                 ptr_q    [N_VOICES];
  logic [AW-1:0]                 ptr_d    [N_VOICES];
  logic [PW-1:0]                 burst_q  [N_VOICES];
  logic [PW-1:0]                 burst_d  [N_VOICES];
  logic signed [DATA_WIDTH-1:0]  last_q   [N_VOICES];
  logic signed [DATA_WIDTH-1:0]  last_d   [N_VOICES];

  logic signed [DATA_WIDTH-1:0]  mem [DEPTH];
  logic signed [DATA_WIDTH-1:0]  rd_data_q;
  logic                          mem_we, mem_re;
  logic [CW-1:0]                 mem_waddr, mem_raddr;
  logic signed [DATA_WIDTH-1:0]  mem_wdata;

  logic signed [DATA_WIDTH:0]    avg_s;
  logic signed [PRODW-1:0]       prod_s;
  logic signed [DATA_WIDTH-1:0]  y_dec_s, noise_s, y_s;
  logic [PW-1:0]                 per_clamp_s;

  // Averaging/decay datapath for the voice currently in WR, plus pluck period clamp
  always_comb begin
    avg_s   = (DATA_WIDTH+1)'(rd_data_q) + (DATA_WIDTH+1)'(last_q[voice_q]);
    prod_s  = PRODW'(avg_s) * PRODW'($signed({1'b0, decay_q[voice_q]}));
    y_dec_s = DATA_WIDTH'(prod_s >>> (DATA_WIDTH + 1));
    if (!prbs_data_i[1]) begin
      noise_s = '0;
    end else if (prbs_data_i[0]) begin
      noise_s = NOISE_POS;
    end else begin
      noise_s = NOISE_NEG;
    end
    if (burst_q[voice_q] != '0) begin
      y_s = noise_s;
    end else begin
      y_s = y_dec_s;
    end
    if (pluck_period_i < PER_MIN) begin
      per_clamp_s = PER_MIN;
    end else if (pluck_period_i > PER_MAX) begin
      per_clamp_s = PER_MAX;
    end else begin
      per_clamp_s = pluck_period_i;
    end
  end

  // Next-state logic for the frame sequencer, per-voice state and outputs
  always_comb begin
    state_d   = state_q;
    voice_d   = voice_q;
    clr_d     = clr_q;
    freeze_d  = freeze_q;
    acc_d     = acc_q;
    overrun_d = overrun_q | (sample_tick_i && (state_q != S_IDLE));
    sample_d  = sample_q;
    idx_d     = idx_q;
    vvalid_d  = 1'b0;
    mix_d     = mix_q;
    mvalid_d  = 1'b0;
    period_d  = period_q;
    decay_d   = decay_q;
    ptr_d     = ptr_q;
    burst_d   = burst_q;
    last_d    = last_q;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_waddr = clr_q;
    mem_wdata = '0;
    mem_raddr = {voice_q, ptr_q[voice_q]};
    case (state_q)
      S_CLEAR: begin
        mem_we = 1'b1;
        clr_d  = clr_q + CW'(1);
        if (clr_q == CLR_LAST) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_CLEAR;
        end
      end
      S_IDLE: begin
        if (sample_tick_i) begin
          state_d  = S_RD;
          voice_d  = '0;
          freeze_d = freeze_i;
          acc_d    = '0;
        end else begin
          state_d  = S_IDLE;
        end
        // A pluck landing with the tick is applied before that frame's first read
        if (pluck_valid_i) begin
          period_d[pluck_voice_i] = per_clamp_s;
          decay_d[pluck_voice_i]  = pluck_decay_i;
          ptr_d[pluck_voice_i]    = '0;
          burst_d[pluck_voice_i]  = per_clamp_s;
          last_d[pluck_voice_i]   = '0;
        end else begin
          period_d = period_q;
        end
      end
      S_RD: begin
        mem_re  = 1'b1;
        state_d = S_WR;
      end
      S_WR: begin
        vvalid_d = 1'b1;
        idx_d    = voice_q;
        if (freeze_q) begin
          sample_d = rd_data_q;
          acc_d    = acc_q + MW'(rd_data_q);
        end else begin
          sample_d          = y_s;
          acc_d             = acc_q + MW'(y_s);
          mem_we            = 1'b1;
          mem_waddr         = {voice_q, ptr_q[voice_q]};
          mem_wdata         = y_s;
          last_d[voice_q]   = rd_data_q;
          if ({1'b0, ptr_q[voice_q]} == period_q[voice_q] - PW'(1)) begin
            ptr_d[voice_q] = '0;
          end else begin
            ptr_d[voice_q] = ptr_q[voice_q] + AW'(1);
          end
          if (burst_q[voice_q] != '0) begin
            burst_d[voice_q] = burst_q[voice_q] - PW'(1);
          end else begin
            burst_d[voice_q] = burst_q[voice_q];
          end
        end
        voice_d = voice_q + VW'(1);
        if (voice_q == VW'(N_VOICES - 1)) begin
          state_d = S_MIX;
        end else begin
          state_d = S_RD;
        end
      end
      S_MIX: begin
        mix_d    = acc_q;
        mvalid_d = 1'b1;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_CLEAR;
        clr_d   = '0;
      end
    endcase
  end

  // State registers with synchronous reset into CLEAR
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_CLEAR;
      voice_q   <= '0;
      clr_q     <= '0;
      freeze_q  <= 1'b0;
      acc_q     <= '0;
      overrun_q <= 1'b0;
      sample_q  <= '0;
      idx_q     <= '0;
      vvalid_q  <= 1'b0;
      mix_q     <= '0;
      mvalid_q  <= 1'b0;
      for (int i = 0; i < N_VOICES; i++) begin
        period_q[i] <= PER_MIN;
        decay_q[i]  <= '0;
        ptr_q[i]    <= '0;
        burst_q[i]  <= '0;
        last_q[i]   <= '0;
      end
    end else begin
      state_q   <= state_d;
      voice_q   <= voice_d;
      clr_q     <= clr_d;
      freeze_q  <= freeze_d;
      acc_q     <= acc_d;
      overrun_q <= overrun_d;
      sample_q  <= sample_d;
      idx_q     <= idx_d;
      vvalid_q  <= vvalid_d;
      mix_q     <= mix_d;
      mvalid_q  <= mvalid_d;
      period_q  <= period_d;
      decay_q   <= decay_d;
      ptr_q     <= ptr_d;
      burst_q   <= burst_d;
      last_q    <= last_d;
    end
  end

  // Shared sample memory with synchronous read
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
    if (mem_re) begin
      rd_data_q <= mem[mem_raddr];
    end
  end

  assign pluck_ready_o  = (state_q == S_IDLE);
  assign busy_o         = (state_q != S_IDLE);
  assign overrun_o      = overrun_q;
  assign voice_sample_o = sample_q;
  assign voice_idx_o    = idx_q;
  assign voice_valid_o  = vvalid_q;
  assign mix_o          = mix_q;
  assign mix_valid_o    = mvalid_q;

endmodule

// File: tb/tb_ks_poly_string.sv
// Scoreboard bench for ks_poly_string: a behavioural string model queues expected
// per-voice samples and mixes; directed checks cover timing, clamp, freeze and reset.
module tb_ks_poly_string;
  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       tick = 1'b0;
  logic       freeze = 1'b0;
  logic [1:0] prbs = 2'b00;
  logic       pv = 1'b0;
  logic [1:0] pvoice = 2'b00;
  logic [8:0] pper = 9'd0;
  logic [7:0] pdec = 8'd0;
  logic [7:0] vs;
  logic [1:0] vidx;
  logic       vvalid;
  logic [9:0] mix;
  logic       mvalid, ready, busy, overrun;

  ks_poly_string #(.N_VOICES(4), .MAX_LENGTH(256), .DATA_WIDTH(8), .PRBS_WIDTH(2)) dut (
    .clk_i(clk), .rst_i(rst_i), .sample_tick_i(tick), .freeze_i(freeze),
    .prbs_data_i(prbs), .pluck_valid_i(pv), .pluck_ready_o(ready),
    .pluck_voice_i(pvoice), .pluck_period_i(pper), .pluck_decay_i(pdec),
    .voice_sample_o(vs), .voice_idx_o(vidx), .voice_valid_o(vvalid),
    .mix_o(mix), .mix_valid_o(mvalid), .busy_o(busy), .overrun_o(overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;

  typedef struct {bit is_mix; int idx; int val;} exp_t;
  exp_t q[$];
  int got_v[4];
  int vcyc[4];
  int got_mix = 0, mcyc = 0, vcount = 0, mcount = 0, tstart = 0;

  logic signed [7:0] m_mem [4][256];
  int m_per[4], m_dec[4], m_ptr[4], m_burst[4], m_last[4];

  int exp0[6] = '{127, 127, 127, 127, 63, 126};
  int exp1[4] = '{-127, -127, -64, -127};

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int v = 0; v < 4; v++) begin
      for (int a = 0; a < 256; a++) m_mem[v][a] = 8'sd0;
      m_per[v] = 2; m_dec[v] = 0; m_ptr[v] = 0; m_burst[v] = 0; m_last[v] = 0;
    end
  endtask

  task automatic m_pluck(input int v, input int per, input int dec);
    int p;
    p = (per < 2) ? 2 : ((per > 256) ? 256 : per);
    m_per[v] = p; m_dec[v] = dec; m_ptr[v] = 0; m_burst[v] = p; m_last[v] = 0;
  endtask

  task automatic m_frame(input bit frz, input logic [1:0] pr);
    int x, y, sum;
    exp_t e;
    sum = 0;
    for (int v = 0; v < 4; v++) begin
      x = m_mem[v][m_ptr[v]];
      if (frz) begin
        y = x;
      end else begin
        if (m_burst[v] > 0) begin
          y = pr[1] ? (pr[0] ? 127 : -127) : 0;
          m_burst[v]--;
        end else begin
          y = ((x + m_last[v]) * m_dec[v]) >>> 9;
        end
        m_mem[v][m_ptr[v]] = y[7:0];
        m_last[v] = x;
        m_ptr[v] = (m_ptr[v] == m_per[v] - 1) ? 0 : m_ptr[v] + 1;
      end
      e.is_mix = 1'b0; e.idx = v; e.val = y;
      q.push_back(e);
      sum += y;
    end
    e.is_mix = 1'b1; e.idx = 0; e.val = sum;
    q.push_back(e);
  endtask

  // Advance to the next falling edge and score any output pulses seen there
  task automatic step();
    exp_t e;
    @(negedge clk);
    if (!rst_i) begin
      if (vvalid) begin
        vcount++;
        chk("voice_expected", int'(q.size() > 0), 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("voice_kind", int'(e.is_mix), 0);
          chk("voice_idx", int'(vidx), e.idx);
          chk("voice_val", $signed(vs), e.val);
        end
        got_v[vidx] = $signed(vs);
        vcyc[vidx] = cyc;
      end
      if (mvalid) begin
        mcount++;
        chk("mix_expected", int'(q.size() > 0), 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("mix_kind", int'(e.is_mix), 1);
          chk("mix_val", $signed(mix), e.val);
        end
        got_mix = $signed(mix);
        mcyc = cyc;
      end
    end
  endtask

  task automatic pluck_set(input int v, input int per, input int dec);
    pv = 1'b1; pvoice = v[1:0]; pper = per[8:0]; pdec = dec[7:0];
    m_pluck(v, per, dec);
  endtask

  task automatic pluck(input int v, input int per, input int dec);
    pluck_set(v, per, dec);
    chk("pluck_ready", int'(ready), 1);
    step();
    pv = 1'b0;
  endtask

  task automatic frame(input bit frz, input logic [1:0] pr);
    tstart = cyc;
    tick = 1'b1; freeze = frz; prbs = pr;
    m_frame(frz, pr);
    step();
    tick = 1'b0; freeze = 1'b0; pv = 1'b0;
    repeat (9) step();
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 3000) begin
      step();
      n++;
    end
    chk(tag, int'(busy), 0);
  endtask

  initial begin
    int cnt, rdy_bad, vc0, mc0;
    repeat (3) step();
    rst_i = 1'b0;
    cnt = 0; rdy_bad = 0;
    for (int i = 0; i < 2000 && busy; i++) begin
      cnt++;
      if (ready) rdy_bad++;
      step();
    end
    chk("clear_cycles", cnt, 1024);
    chk("ready_during_clear", rdy_bad, 0);
    chk("idle_ready", int'(ready), 1);
    chk("idle_sample", int'(vs), 0);
    chk("idle_mix", int'(mix), 0);
    chk("idle_vvalid", int'(vvalid), 0);
    chk("idle_mvalid", int'(mvalid), 0);
    chk("idle_overrun", int'(overrun), 0);
    m_reset();

    // Voice 0 burst of +127 then averaging decay; timing of pulses per frame
    prbs = 2'b11;
    pluck(0, 4, 255);
    for (int f = 0; f < 6; f++) begin
      vc0 = vcount; mc0 = mcount;
      frame(1'b0, 2'b11);
      chk("v0_seq", got_v[0], exp0[f]);
      chk("v1_silent", got_v[1], 0);
      chk("v3_silent", got_v[3], 0);
      chk("mix_eq_v0", got_mix, exp0[f]);
      chk("voice_pulses", vcount - vc0, 4);
      chk("mix_pulses", mcount - mc0, 1);
      for (int v = 0; v < 4; v++) chk("voice_cycle", vcyc[v], tstart + 3 + 2 * v);
      chk("mix_cycle", mcyc, tstart + 10);
    end

    // Voice 1 period 1 clamps to 2, pluck accepted together with the tick
    for (int f = 0; f < 4; f++) begin
      if (f == 0) pluck_set(1, 1, 255);
      frame(1'b0, 2'b10);
      chk("v1_seq", got_v[1], exp1[f]);
    end

    // Tick during a frame is dropped and flagged
    chk("overrun_before", int'(overrun), 0);
    vc0 = vcount; mc0 = mcount;
    tick = 1'b1; prbs = 2'b10;
    m_frame(1'b0, 2'b10);
    step();
    tick = 1'b0;
    repeat (3) step();
    tick = 1'b1;
    step();
    tick = 1'b0;
    repeat (5) step();
    chk("overrun_set", int'(overrun), 1);
    chk("overrun_voice_pulses", vcount - vc0, 4);
    chk("overrun_mix_pulses", mcount - mc0, 1);
    repeat (12) step();
    chk("no_extra_frame", vcount - vc0, 4);
    chk("overrun_sticky", int'(overrun), 1);
    chk("queue_after_overrun", q.size(), 0);

    // Freeze during voices 0 and 2 burst
    pluck(1, 2, 0);
    frame(1'b0, 2'b00);
    frame(1'b0, 2'b00);
    pluck(0, 4, 255);
    pluck(2, 4, 255);
    for (int f = 0; f < 4; f++) begin
      frame(1'b0, 2'b11);
      chk("burst_v0", got_v[0], 127);
      chk("burst_v2", got_v[2], 127);
      chk("burst_mix", got_mix, 254);
    end
    frame(1'b1, 2'b11);
    chk("frozen_v0", got_v[0], 127);
    chk("frozen_v2", got_v[2], 127);
    chk("frozen_mix", got_mix, 254);
    frame(1'b0, 2'b11);
    chk("after_freeze_v2_a", got_v[2], 63);
    frame(1'b0, 2'b11);
    chk("after_freeze_v2_b", got_v[2], 126);

    // Reset during the read of voice 2
    tick = 1'b1; prbs = 2'b11;
    m_frame(1'b0, 2'b11);
    step();
    tick = 1'b0;
    repeat (4) step();
    rst_i = 1'b1;
    step();
    chk("rst_busy", int'(busy), 1);
    chk("rst_ready", int'(ready), 0);
    chk("rst_sample", int'(vs), 0);
    chk("rst_vvalid", int'(vvalid), 0);
    chk("rst_mix", int'(mix), 0);
    chk("rst_mvalid", int'(mvalid), 0);
    chk("rst_overrun", int'(overrun), 0);
    q.delete();
    m_reset();
    step();
    rst_i = 1'b0;
    wait_idle("reclear_done");
    for (int f = 0; f < 3; f++) begin
      frame(1'b0, 2'b11);
      for (int v = 0; v < 4; v++) chk("silent_after_reset", got_v[v], 0);
      chk("silent_mix", got_mix, 0);
    end
    chk("queue_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
